// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared sizing constants and state type for the L2 line array
package l2_pkg;

  localparam int L2_WIDTH = 256;
  localparam int L2_DEPTH = 32;

  typedef enum logic {L2A_IDLE, L2A_CLEAR} l2a_state_t;

endpackage

// File: rtl/l2_byte_merge.sv
// rtl/l2_byte_merge.sv - byte-enable merge of new write data over an existing line
module l2_byte_merge #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0]   old_line,
  input  logic [WIDTH-1:0]   datain,
  input  logic [WIDTH/8-1:0] wmask,
  output logic [WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_line;
    for (int b = 0; b < WIDTH/8; b++) begin
      if (wmask[b]) merged[8*b +: 8] = datain[8*b +: 8];
    end
  end

endmodule

// File: rtl/l2_line_array.sv
// rtl/l2_line_array.sv - L2 line store with byte-masked writes, valid bits and clear sweep (optional L2_LINE_ARRAY_PARITY_EN)
module l2_line_array
  import l2_pkg::*;
#(
  parameter int WIDTH = L2_WIDTH,
  parameter int DEPTH = L2_DEPTH,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write,
  input  logic [WIDTH/8-1:0] wmask,
  input  logic [IDXW-1:0]    index,
  input  logic [WIDTH-1:0]   datain,
  input  logic               flush_req,
  output logic [WIDTH-1:0]   dataout,
  output logic               valid_out,
  output logic               busy
`ifdef L2_LINE_ARRAY_PARITY_EN
  ,
  output logic               parity_err
`endif
);

  localparam logic [IDXW:0]   DEPTH_L = (IDXW+1)'(DEPTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  l2a_state_t state, next_state;
  logic [IDXW-1:0] clr_idx, next_clr_idx;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] merged;
  logic             in_range;

  assign in_range = ({1'b0, index} < DEPTH_L);
  assign busy     = (state == L2A_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= L2A_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= next_state;
      clr_idx <= next_clr_idx;
    end
  end

  always_comb begin
    next_state   = state;
    next_clr_idx = clr_idx;
    case (state)
      L2A_CLEAR: begin
        if (clr_idx == LAST_IDX) begin
          next_state   = L2A_IDLE;
          next_clr_idx = '0;
        end else begin
          next_clr_idx = clr_idx + 1'b1;
        end
      end
      default: begin
        if (flush_req) begin
          next_state   = L2A_CLEAR;
          next_clr_idx = '0;
        end
      end
    endcase
  end

  l2_byte_merge #(.WIDTH(WIDTH)) u_merge (
    .old_line (mem[index]),
    .datain   (datain),
    .wmask    (wmask),
    .merged   (merged)
  );

  // A write that coincides with flush_req lands here first; the sweep then wipes it.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_idx] <= '0;
      vld[clr_idx] <= 1'b0;
    end else if (!rst && write && in_range) begin
      mem[index] <= merged;
      vld[index] <= 1'b1;
    end
  end

  assign dataout   = (busy || !in_range) ? '0 : mem[index];
  assign valid_out = !busy && in_range && vld[index];

`ifdef L2_LINE_ARRAY_PARITY_EN
  logic [DEPTH-1:0] par_bits;

  always_ff @(posedge clk) begin
    if (busy) begin
      par_bits[clr_idx] <= 1'b0;
    end else if (!rst && write && in_range) begin
      par_bits[index] <= ^merged;
    end
  end

  assign parity_err = valid_out & (^dataout ^ par_bits[index]);
`endif

endmodule

// File: tb/tb_l2_line_array.sv
// tb/tb_l2_line_array.sv - self-checking bench for l2_line_array
module tb_l2_line_array;
  import l2_pkg::*;

  localparam int W = L2_WIDTH;
  localparam int D = L2_DEPTH;
  localparam int IW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst, write, flush_req;
  logic [W/8-1:0] wmask;
  logic [IW-1:0] index;
  logic [W-1:0]  datain;
  logic [W-1:0]  dataout;
  logic          valid_out, busy;
`ifdef L2_LINE_ARRAY_PARITY_EN
  logic          parity_err;
`endif

  int checks = 0;
  int failures = 0;
  bit check_en = 0;

  // Reference: array contents, valid bits, and cycles of sweep left.
  logic [W-1:0] m_mem [D];
  bit           m_vld [D];
  int           m_left = 0;

  always #5 clk = ~clk;

  l2_line_array dut (
    .clk       (clk),
    .rst       (rst),
    .write     (write),
    .wmask     (wmask),
    .index     (index),
    .datain    (datain),
    .flush_req (flush_req),
    .dataout   (dataout),
    .valid_out (valid_out),
    .busy      (busy)
`ifdef L2_LINE_ARRAY_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < D; i++) begin
      m_mem[i] = '0;
      m_vld[i] = 0;
    end
  endtask

  // Sweep contents are invisible while busy, so the model wipes at sweep start.
  always @(posedge clk) begin
    if (rst) begin
      m_left = D;
      zero_model();
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else begin
      if (write && int'(index) < D) begin
        for (int b = 0; b < W/8; b++)
          if (wmask[b]) m_mem[index][8*b +: 8] = datain[8*b +: 8];
        m_vld[index] = 1;
      end
      if (flush_req) begin
        m_left = D;
        zero_model();
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_busy", W'(busy), W'(m_left > 0));
      chk("model_dataout", dataout, (m_left > 0) ? '0 : m_mem[index]);
      chk("model_valid", W'(valid_out), (m_left > 0) ? '0 : W'(m_vld[index]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      tick();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [W-1:0] a5, c3, mix;
    a5  = {32{8'hA5}};
    c3  = {32{8'h3C}};
    mix = {{30{8'hA5}}, {2{8'h3C}}};

    rst = 1; write = 0; flush_req = 0; wmask = '0; index = '0; datain = '0;
    tick();
    check_en = 1;
    @(negedge clk);
    chk("reset_busy", W'(busy), W'(1));
    chk("reset_dataout", dataout, '0);
    chk("reset_valid", W'(valid_out), '0);
    tick(); tick();
    rst = 0;
    count_busy(n);
    chk("reset_sweep_len", W'(n), W'(32));

    for (int i = 0; i < D; i++) begin
      tick();
      index = IW'(i);
      @(negedge clk);
      chk("swept_data", dataout, '0);
      chk("swept_valid", W'(valid_out), '0);
    end

    // Full write: not visible before the edge, visible after.
    tick();
    write = 1; index = 5; wmask = '1; datain = a5;
    @(negedge clk);
    chk("pre_write_data", dataout, '0);
    tick();
    write = 0;
    @(negedge clk);
    chk("full_write_data", dataout, a5);
    chk("full_write_valid", W'(valid_out), W'(1));
    tick();
    index = 6;
    @(negedge clk);
    chk("neighbour_data", dataout, '0);
    chk("neighbour_valid", W'(valid_out), '0);

    tick();
    write = 1; index = 5; wmask = 32'h0000_0003; datain = c3;
    tick();
    write = 0;
    @(negedge clk);
    chk("masked_write", dataout, mix);

    // All-zero mask still marks the line valid.
    tick();
    write = 1; index = 7; wmask = '0; datain = '1;
    tick();
    write = 0;
    @(negedge clk);
    chk("zero_mask_data", dataout, '0);
    chk("zero_mask_valid", W'(valid_out), W'(1));

    // Flush with a write attempted mid-sweep.
    tick();
    flush_req = 1;
    tick();
    flush_req = 0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      tick();
      write = (i == 9); index = 5; wmask = '1; datain = '1;
    end
    write = 0;
    chk("flush_sweep_len", W'(n), W'(32));
    tick();
    index = 5;
    @(negedge clk);
    chk("flushed_data", dataout, '0);
    chk("flushed_valid", W'(valid_out), '0);

    // Reset ten cycles into a sweep restarts it.
    tick();
    write = 1; index = 3; wmask = '1; datain = a5;
    tick();
    write = 0; flush_req = 1;
    tick();
    flush_req = 0;
    repeat (10) tick();
    rst = 1;
    tick();
    rst = 0;
    count_busy(n);
    chk("restart_sweep_len", W'(n), W'(32));

    // Write and flush in the same cycle.
    tick();
    write = 1; flush_req = 1; index = 9; wmask = '1; datain = {32{8'h5A}};
    tick();
    write = 0; flush_req = 0;
    count_busy(n);
    chk("collision_sweep_len", W'(n), W'(32));
    tick();
    index = 9;
    @(negedge clk);
    chk("collision_data", dataout, '0);
    chk("collision_valid", W'(valid_out), '0);

`ifdef L2_LINE_ARRAY_PARITY_EN
    tick();
    write = 1; index = 2; wmask = '1; datain = W'(1);
    tick();
    write = 0;
    @(negedge clk);
    chk("parity_clean", W'(parity_err), '0);
    tick();
    dut.par_bits[2] = ~dut.par_bits[2];
    @(negedge clk);
    chk("parity_flipped", W'(parity_err), W'(1));
    tick();
    index = 3;
    @(negedge clk);
    chk("parity_other", W'(parity_err), '0);
`endif

    tick();
    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
